// File: rtl/spi_slave_responder.sv
// SPI slave endpoint for the 12-bit LSB-first master.
// Receives mosi into dout and, in the same frame, shifts a host-loaded
// response word out on miso. All SPI pins are raw and asynchronous to clk.
// They are synchronized and edge-detected here, so every sclk half period
// must last several clk cycles.
module spi_slave_responder #(
   parameter int WIDTH       = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs,
   input  logic             mosi,
   output logic             miso,
   output logic [WIDTH-1:0] dout,
   output logic             done,
   output logic             frame_err,
   output logic             busy,
   input  logic [WIDTH-1:0] tx_din,
   input  logic             tx_load
);

   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam int WARM_W = $clog2(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      WAIT_CS_HIGH = 2'd0,
      IDLE         = 2'd1,
      ACTIVE       = 2'd2
   } state_t;

   // Synchronizer chains and the extra registered copies used for edge detection.
   logic [SYNC_STAGES-1:0] csSync_q;
   logic [SYNC_STAGES-1:0] sclkSync_q;
   logic [SYNC_STAGES-1:0] mosiSync_q;
   logic                   cs_q;
   logic                   sclk_q;

   logic                   cs_s;
   logic                   sclk_s;
   logic                   mosi_s;
   logic                   rise;
   logic                   fall;
   logic                   riseCounted;

   // Post-reset settle counter: the cs chain holds its reset value (high)
   // until real samples reach the end of the chain.
   logic [WARM_W-1:0]      warmCnt_q;
   logic                   syncReady;

   // Frame state.
   state_t                 state_q,    state_d;
   logic [WIDTH-1:0]       shiftTx_q,  shiftTx_d;
   logic [WIDTH-1:0]       shiftRx_q,  shiftRx_d;
   logic [CNT_W-1:0]       txCnt_q,    txCnt_d;
   logic [CNT_W-1:0]       rxCnt_q,    rxCnt_d;
   logic                   armed_q,    armed_d;
   logic [WIDTH-1:0]       txHold_q,   txHold_d;
   logic [WIDTH-1:0]       dout_q,     dout_d;
   logic                   done_q,     done_d;
   logic                   frameErr_q, frameErr_d;
   logic                   miso_q,     miso_d;

   assign cs_s        = csSync_q[SYNC_STAGES-1];
   assign sclk_s      = sclkSync_q[SYNC_STAGES-1];
   assign mosi_s      = mosiSync_q[SYNC_STAGES-1];
   assign rise        = sclk_s & ~sclk_q;
   assign fall        = ~sclk_s & sclk_q;
   // A rise seen while the delayed cs is still high is the master's select edge, not a data edge.
   assign riseCounted = rise & ~cs_q;
   assign syncReady   = (warmCnt_q == WARM_W'(SYNC_STAGES));

   // Shift raw pins through the synchronizers; cs idles high so it resets high.
   always_ff @(posedge clk) begin
      if (rst) begin
         csSync_q   <= '1;
         sclkSync_q <= '0;
         mosiSync_q <= '0;
         cs_q       <= 1'b1;
         sclk_q     <= 1'b0;
      end else begin
         csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs};
         sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
         mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
         cs_q       <= cs_s;
         sclk_q     <= sclk_s;
      end
   end

   // Count cycles after reset until the synchronizers carry real pin samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         warmCnt_q <= '0;
      end else if (!syncReady) begin
         warmCnt_q <= warmCnt_q + WARM_W'(1);
      end
   end

   // Register every piece of frame state and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_CS_HIGH;
         shiftTx_q  <= '0;
         shiftRx_q  <= '0;
         txCnt_q    <= '0;
         rxCnt_q    <= '0;
         armed_q    <= 1'b0;
         txHold_q   <= '0;
         dout_q     <= '0;
         done_q     <= 1'b0;
         frameErr_q <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shiftTx_q  <= shiftTx_d;
         shiftRx_q  <= shiftRx_d;
         txCnt_q    <= txCnt_d;
         rxCnt_q    <= rxCnt_d;
         armed_q    <= armed_d;
         txHold_q   <= txHold_d;
         dout_q     <= dout_d;
         done_q     <= done_d;
         frameErr_q <= frameErr_d;
         miso_q     <= miso_d;
      end
   end

   // Frame sequencing: start on cs low, shift miso on counted rises and
   // mosi on armed falls, then finish with done or abort with frame_err.
   always_comb begin
      state_d    = state_q;
      shiftTx_d  = shiftTx_q;
      shiftRx_d  = shiftRx_q;
      txCnt_d    = txCnt_q;
      rxCnt_d    = rxCnt_q;
      armed_d    = armed_q;
      dout_d     = dout_q;
      done_d     = 1'b0;
      frameErr_d = 1'b0;
      miso_d     = miso_q;
      txHold_d   = tx_load ? tx_din : txHold_q;

      case (state_q)
         WAIT_CS_HIGH: begin
            miso_d = 1'b0;
            if (syncReady && cs_s) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            miso_d = 1'b0;
            if (!cs_s) begin
               // A load on this very cycle is sent now rather than waiting a frame.
               shiftTx_d = tx_load ? tx_din : txHold_q;
               txCnt_d   = '0;
               rxCnt_d   = '0;
               armed_d   = 1'b0;
               state_d   = ACTIVE;
            end
         end

         ACTIVE: begin
            if (riseCounted) begin
               armed_d = 1'b1;
               if (txCnt_q < CNT_W'(WIDTH)) begin
                  miso_d    = shiftTx_q[0];
                  shiftTx_d = {1'b0, shiftTx_q[WIDTH-1:1]};
                  txCnt_d   = txCnt_q + CNT_W'(1);
               end
            end

            if (fall && armed_q) begin
               shiftRx_d = {mosi_s, shiftRx_q[WIDTH-1:1]};
               rxCnt_d   = rxCnt_q + CNT_W'(1);
               armed_d   = 1'b0;
            end

            // The final sample wins over a cs rise detected on the same cycle.
            if (fall && armed_q && (rxCnt_q == CNT_W'(WIDTH - 1))) begin
               dout_d  = {mosi_s, shiftRx_q[WIDTH-1:1]};
               done_d  = 1'b1;
               state_d = WAIT_CS_HIGH;
            end else if (cs_s) begin
               frameErr_d = 1'b1;
               miso_d     = 1'b0;
               state_d    = IDLE;
            end
         end

         default: begin
            miso_d  = 1'b0;
            state_d = WAIT_CS_HIGH;
         end
      endcase
   end

   assign miso      = miso_q;
   assign dout      = dout_q;
   assign done      = done_q;
   assign frame_err = frameErr_q;
   assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: directed frames followed by
// random frames, checked against a word-level model of the link.
module tb_spi_slave_responder;

   localparam int WIDTH = 12;
   localparam int HALF  = 11;
   localparam int GAP   = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             sclk;
   logic             cs;
   logic             mosi;
   logic             miso;
   logic [WIDTH-1:0] dout;
   logic             done;
   logic             frame_err;
   logic             busy;
   logic [WIDTH-1:0] tx_din;
   logic             tx_load;

   int assertCount = 0;
   int failCount   = 0;
   int doneCnt     = 0;
   int errCnt      = 0;
   int bothCnt     = 0;

   // Model: the response register the host last loaded, and the last finished word.
   logic [WIDTH-1:0] txHoldModel;
   logic [WIDTH-1:0] doutModel;

   spi_slave_responder #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .cs        (cs),
      .mosi      (mosi),
      .miso      (miso),
      .dout      (dout),
      .done      (done),
      .frame_err (frame_err),
      .busy      (busy),
      .tx_din    (tx_din),
      .tx_load   (tx_load)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Count pulse cycles of done and frame_err, plus any cycle where both are high.
   always @(negedge clk) begin
      if (done === 1'b1) doneCnt++;
      if (frame_err === 1'b1) errCnt++;
      if (done === 1'b1 && frame_err === 1'b1) bothCnt++;
   end

   // Stop a hung run with a failure line.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic loadTx(input logic [WIDTH-1:0] v);
      tx_din  = v;
      tx_load = 1'b1;
      tick(1);
      tx_load = 1'b0;
      txHoldModel = v;
   endtask

   // One master frame of nBits LSB-first bits. Optional mid-frame tx_load at
   // bit loadAt, optional reset at bit rstAt, and endGap cycles between the
   // last sclk fall and cs rising (0 = same instant).
   task automatic applyStimulus(input logic [WIDTH-1:0] din, input int nBits, input int loadAt,
                                input logic [WIDTH-1:0] loadVal, input int rstAt, input int endGap);
      logic [WIDTH-1:0] txSend;
      int               d0;
      int               e0;
      logic             killed;
      txSend = txHoldModel;
      d0     = doneCnt;
      e0     = errCnt;
      killed = 1'b0;
      cs     = 1'b0;
      tick(HALF);
      for (int i = 0; i < nBits; i++) begin
         if (i == rstAt) begin
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            killed = 1'b1;
            txHoldModel = '0;
            doutModel = '0;
            @(negedge clk);
            checkOutput("rstMiso", 32'(miso), 32'd0);
            checkOutput("rstDout", 32'(dout), 32'd0);
            checkOutput("rstBusy", 32'(busy), 32'd0);
            checkOutput("rstDone", 32'(done), 32'd0);
            checkOutput("rstErr", 32'(frame_err), 32'd0);
            tick(1);
         end
         tick(5);
         mosi = din[i];
         if (i == loadAt) begin
            tx_din  = loadVal;
            tx_load = 1'b1;
            tick(1);
            tx_load = 1'b0;
            txHoldModel = loadVal;
            tick(5);
         end else begin
            tick(6);
         end
         sclk = 1'b1;
         tick(HALF - 1);
         @(negedge clk);
         if (!killed) begin
            checkOutput($sformatf("miso[%0d]", i), 32'(miso), 32'(txSend[i]));
            checkOutput("busyMid", 32'(busy), 32'd1);
         end
         tick(1);
         sclk = 1'b0;
         if (i == nBits - 1 && endGap == 0) cs = 1'b1;
      end
      if (endGap > 0) begin
         tick(endGap);
         cs = 1'b1;
      end
      tick(GAP);
      @(negedge clk);
      if (killed) begin
         checkOutput("rstNoDone", 32'(doneCnt - d0), 32'd0);
         checkOutput("rstNoErr", 32'(errCnt - e0), 32'd0);
      end else if (nBits == WIDTH) begin
         doutModel = din;
         checkOutput("doneCount", 32'(doneCnt - d0), 32'd1);
         checkOutput("errCount", 32'(errCnt - e0), 32'd0);
      end else begin
         checkOutput("abortDone", 32'(doneCnt - d0), 32'd0);
         checkOutput("abortErr", 32'(errCnt - e0), 32'd1);
      end
      checkOutput("dout", 32'(dout), 32'(doutModel));
      checkOutput("idleMiso", 32'(miso), 32'd0);
      checkOutput("idleBusy", 32'(busy), 32'd0);
      tick(1);
   endtask

   initial begin
      logic [WIDTH-1:0] din;
      int               nBits;
      int               loadAt;
      int               endGap;
      rst = 1'b1;
      cs = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      tx_load = 1'b0;
      tx_din = '0;
      txHoldModel = '0;
      doutModel = '0;
      tick(3);
      @(negedge clk);
      checkOutput("resetMiso", 32'(miso), 32'd0);
      checkOutput("resetDout", 32'(dout), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetErr", 32'(frame_err), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(10);

      $display("[TB] power-up frame with no load");
      applyStimulus(12'h5A3, WIDTH, -1, 12'h000, -1, HALF);

      $display("[TB] loaded response 3C1, receive A5C");
      loadTx(12'h3C1);
      applyStimulus(12'hA5C, WIDTH, -1, 12'h000, -1, HALF);

      $display("[TB] abort after 5 bits, then 123");
      applyStimulus(12'h0F0, 5, -1, 12'h000, -1, HALF);
      applyStimulus(12'h123, WIDTH, -1, 12'h000, -1, HALF);

      $display("[TB] back-to-back 001 then FFF");
      applyStimulus(12'h001, WIDTH, -1, 12'h000, -1, 0);
      applyStimulus(12'hFFF, WIDTH, -1, 12'h000, -1, 0);

      $display("[TB] double buffering of tx_hold");
      loadTx(12'h3C1);
      applyStimulus(12'h2B4, WIDTH, 4, 12'h555, -1, HALF);
      applyStimulus(12'h6D1, WIDTH, -1, 12'h000, -1, HALF);
      applyStimulus(12'h1E8, WIDTH, -1, 12'h000, -1, HALF);

      $display("[TB] reset mid-frame, then 7E7");
      applyStimulus(12'h3A6, WIDTH, -1, 12'h000, 6, HALF);
      applyStimulus(12'h7E7, WIDTH, -1, 12'h000, -1, HALF);

      $display("[TB] random frames");
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 1) == 1) loadTx(12'($urandom));
         din    = 12'($urandom);
         nBits  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH - 1)) : WIDTH;
         loadAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nBits - 1)) : -1;
         endGap = ($urandom_range(0, 1) == 1) ? 0 : HALF;
         applyStimulus(din, nBits, loadAt, 12'($urandom), -1, endGap);
      end

      checkOutput("doneWithErr", 32'(bothCnt), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
